// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: FSM state and access owner
// encodings, counter widths and the starvation test used by the winner select.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LD    = 1'b1
  } owner_e;

  // MEM_LAT tops out at 7, so lat_cnt never needs more than 3 bits;
  // STARVE_MAX tops out at 15, so starve_cnt fits in 4.
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  function automatic logic starved(input logic [STARVE_W-1:0] cnt,
                                   input int unsigned         limit);
    return cnt == STARVE_W'(limit);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the arbiter and its neighbours: fetch port, loader port
// and the single-port instruction memory. The arbiter uses the slave view.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_flush;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              stall_fetch;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, fetch_flush,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, stall_fetch,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, fetch_flush,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, stall_fetch,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_arbiter_pick.sv
// Combinational winner select: the loader normally has priority, but a fetch
// that has watched STARVE_MAX loader grants in a row is let through first.
module imem_arb_pick
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                fetch_req_i,
  input  logic                ld_req_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                valid_o,
  output owner_e              owner_o
);

  always_comb begin
    valid_o = fetch_req_i | ld_req_i;
    owner_o = OWN_FETCH;
    if (fetch_req_i && starved(starve_cnt_i, STARVE_MAX)) begin
      owner_o = OWN_FETCH;
    end else if (ld_req_i) begin
      owner_o = OWN_LD;
    end else begin
      owner_o = OWN_FETCH;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares a fixed-latency single-port imem between
// fetch reads and loader writes/readbacks, one access in flight at a time.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   fetch_rdata_q, fetch_rdata_d;
  logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;

  logic   pick_valid;
  owner_e pick_owner;
  logic   grant;
  logic   lat_done;

  imem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .fetch_req_i  (bus.fetch_req),
    .ld_req_i     (bus.ld_req),
    .starve_cnt_i (starve_cnt_q),
    .valid_o      (pick_valid),
    .owner_o      (pick_owner)
  );

  // Grants are held off while reset is asserted, even though the FSM sits in IDLE.
  assign grant    = (state_q == ST_IDLE) && rst && pick_valid;
  assign lat_done = (lat_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (lat_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A flush seen in the DONE cycle itself still suppresses that fetch response.
  always_comb begin
    bus.fetch_gnt    = grant && (pick_owner == OWN_FETCH);
    bus.ld_gnt       = grant && (pick_owner == OWN_LD);
    bus.stall_fetch  = bus.fetch_req && !bus.fetch_gnt;
    bus.mem_en       = (state_q == ST_ISSUE);
    bus.mem_we       = (state_q == ST_ISSUE) && we_q;
    bus.mem_addr     = addr_q;
    bus.mem_wdata    = wdata_q;
    bus.fetch_rvalid = (state_q == ST_DONE) && rst && (owner_q == OWN_FETCH)
                       && !drop_q && !bus.fetch_flush;
    bus.ld_rvalid    = (state_q == ST_DONE) && rst && (owner_q == OWN_LD);
    bus.fetch_rdata  = fetch_rdata_q;
    bus.ld_rdata     = ld_rdata_q;
  end

  always_comb begin
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    lat_cnt_d     = lat_cnt_q;
    starve_cnt_d  = starve_cnt_q;
    drop_d        = drop_q;
    fetch_rdata_d = fetch_rdata_q;
    ld_rdata_d    = ld_rdata_q;

    if (grant) begin
      owner_d = pick_owner;
      if (pick_owner == OWN_LD) begin
        we_d    = bus.ld_we;
        addr_d  = bus.ld_addr;
        wdata_d = bus.ld_wdata;
      end else begin
        we_d    = 1'b0;
        addr_d  = bus.fetch_addr;
        wdata_d = '0;
      end
    end

    if (!bus.fetch_req) begin
      starve_cnt_d = '0;
    end else if (grant && (pick_owner == OWN_FETCH)) begin
      starve_cnt_d = '0;
    end else if (grant && (pick_owner == OWN_LD) && !starved(starve_cnt_q, STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end

    if (state_q == ST_ISSUE) begin
      lat_cnt_d = LAT_W'(MEM_LAT - 1);
    end else if ((state_q == ST_WAIT) && !lat_done) begin
      lat_cnt_d = lat_cnt_q - LAT_W'(1);
    end

    // Writes still wait out the full latency and report zero as readback.
    if ((state_q == ST_WAIT) && lat_done) begin
      if (owner_q == OWN_FETCH) begin
        fetch_rdata_d = bus.mem_rdata;
      end else begin
        ld_rdata_d = we_q ? '0 : bus.mem_rdata;
      end
    end

    if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
      drop_d = 1'b0;
    end else if (bus.fetch_flush && (owner_q == OWN_FETCH)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q       <= OWN_FETCH;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      lat_cnt_q     <= '0;
      starve_cnt_q  <= '0;
      drop_q        <= 1'b0;
      fetch_rdata_q <= '0;
      ld_rdata_q    <= '0;
    end else begin
      owner_q       <= owner_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      lat_cnt_q     <= lat_cnt_d;
      starve_cnt_q  <= starve_cnt_d;
      drop_q        <= drop_d;
      fetch_rdata_q <= fetch_rdata_d;
      ld_rdata_q    <= ld_rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_imem_arbiter;

  localparam int LAT = 1;
  localparam int SM  = 4;

  logic clk;
  logic rst;

  imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (LAT),
    .STARVE_MAX (SM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory responder driven purely by the DUT memory pins.
  logic [31:0] respMem [logic [31:0]];
  logic [31:0] pipeData [LAT];
  logic        pipeVld  [LAT];
  logic [31:0] junk;

  function automatic logic [31:0] readResp(input logic [31:0] a);
    return respMem.exists(a) ? respMem[a] : initWord(a);
  endfunction

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pipeVld[i]  = 1'b0;
      pipeData[i] = '0;
    end
    junk = 32'h0BAD_F00D;
  end

  always @(posedge clk) begin
    junk <= $urandom;
    for (int i = LAT - 1; i > 0; i--) begin
      pipeData[i] <= pipeData[i-1];
      pipeVld[i]  <= pipeVld[i-1];
    end
    pipeVld[0] <= bus.mem_en;
    if (bus.mem_en) begin
      pipeData[0] <= readResp(bus.mem_addr);
      if (bus.mem_we) respMem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = pipeVld[LAT-1] ? pipeData[LAT-1] : junk;

  // Transaction-level reference model.
  typedef struct packed {
    logic        isLd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] result;
  } tx_t;

  logic [31:0] modelMem [logic [31:0]];
  tx_t         cur;
  int          cyc        = 0;
  int          freeAt     = 0;
  int          gntCycle   = -1000;
  int          starve     = 0;
  bit          drop       = 1'b0;
  bit          modelValid = 1'b0;
  logic [31:0] expFetchRdata = '0;
  logic [31:0] expLdRdata    = '0;
  bit          lastFetchGnt  = 1'b0;
  bit          lastLdGnt     = 1'b0;

  function automatic logic [31:0] readModel(input logic [31:0] a);
    return modelMem.exists(a) ? modelMem[a] : initWord(a);
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [31:0] d);
    modelMem[a] = d;
    respMem[a]  = d;
  endfunction

  always @(negedge clk) begin : compare
    int k;
    bit idle, gF, gL, expEn, doneC;
    if (!modelValid && !rst) modelValid = 1'b1;
    if (modelValid) begin
      idle = (cyc >= freeAt);
      k    = cyc - gntCycle;
      gF   = 1'b0;
      gL   = 1'b0;
      if (idle && rst) begin
        if (bus.fetch_req && starve == SM) gF = 1'b1;
        else if (bus.ld_req)               gL = 1'b1;
        else if (bus.fetch_req)            gF = 1'b1;
      end
      expEn = !idle && (k == 1);
      doneC = !idle && (k == LAT + 2) && rst;

      checkOutput("fetch_gnt", 32'(bus.fetch_gnt), 32'(gF));
      checkOutput("ld_gnt", 32'(bus.ld_gnt), 32'(gL));
      checkOutput("stall_fetch", 32'(bus.stall_fetch), 32'(bus.fetch_req && !gF));
      checkOutput("mem_en", 32'(bus.mem_en), 32'(expEn));
      if (expEn) begin
        checkOutput("mem_we", 32'(bus.mem_we), 32'(cur.we));
        checkOutput("mem_addr", bus.mem_addr, cur.addr);
        if (cur.we) checkOutput("mem_wdata", bus.mem_wdata, cur.wdata);
      end
      checkOutput("fetch_rvalid", 32'(bus.fetch_rvalid),
                  32'(doneC && !cur.isLd && !drop && !bus.fetch_flush));
      checkOutput("ld_rvalid", 32'(bus.ld_rvalid), 32'(doneC && cur.isLd));
      checkOutput("fetch_rdata", bus.fetch_rdata, expFetchRdata);
      checkOutput("ld_rdata", bus.ld_rdata, expLdRdata);

      if (!rst) begin
        freeAt        = cyc + 1;
        gntCycle      = -1000;
        starve        = 0;
        drop          = 1'b0;
        expFetchRdata = '0;
        expLdRdata    = '0;
      end else begin
        if (!idle) begin
          if (k == LAT + 1) begin
            if (cur.isLd) expLdRdata = cur.result;
            else          expFetchRdata = cur.result;
          end
          if (k == LAT + 2)                         drop = 1'b0;
          else if (bus.fetch_flush && !cur.isLd)    drop = 1'b1;
        end else begin
          drop = 1'b0;
        end
        if (!bus.fetch_req)         starve = 0;
        else if (gF)                starve = 0;
        else if (gL && starve < SM) starve++;
        if (gF || gL) begin
          cur.isLd  = gL;
          cur.we    = gL ? bus.ld_we : 1'b0;
          cur.addr  = gL ? bus.ld_addr : bus.fetch_addr;
          cur.wdata = gL ? bus.ld_wdata : 32'h0;
          if (cur.isLd && cur.we) begin
            modelMem[cur.addr] = cur.wdata;
            cur.result = 32'h0;
          end else begin
            cur.result = readModel(cur.addr);
          end
          gntCycle = cyc;
          freeAt   = cyc + LAT + 3;
        end
      end
    end
    lastFetchGnt = bus.fetch_gnt;
    lastLdGnt    = bus.ld_gnt;
    cyc++;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the grant, then drops that request after the grant edge.
  task automatic waitGrant(input bit isLd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (isLd ? bus.ld_gnt : bus.fetch_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput(isLd ? "ld grant timeout" : "fetch grant timeout", 32'd0, 32'd1);
    nextCycle();
    if (isLd) bus.ld_req = 1'b0;
    else      bus.fetch_req = 1'b0;
  endtask

  task automatic applyStimulus();
    nextCycle();
    rst = ($urandom_range(0, 199) != 0);
    if (lastFetchGnt || !bus.fetch_req) begin
      bus.fetch_req  = ($urandom_range(0, 99) < 50);
      bus.fetch_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    end else if ($urandom_range(0, 99) < 3) begin
      bus.fetch_req = 1'b0;
    end
    if (lastLdGnt || !bus.ld_req) begin
      bus.ld_req   = ($urandom_range(0, 99) < 40);
      bus.ld_we    = ($urandom_range(0, 1) == 1);
      bus.ld_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      bus.ld_wdata = $urandom;
    end else if ($urandom_range(0, 99) < 3) begin
      bus.ld_req = 1'b0;
    end
    bus.fetch_flush = ($urandom_range(0, 99) < 10);
  endtask

  initial begin : stimulus
    bit seen;
    int n;
    bit seq [6];
    bit expSeq [6];
    expSeq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst             = 1'b0;
    bus.fetch_req   = 1'b1;
    bus.fetch_addr  = 32'h10;
    bus.fetch_flush = 1'b0;
    bus.ld_req      = 1'b1;
    bus.ld_we       = 1'b0;
    bus.ld_addr     = 32'h40;
    bus.ld_wdata    = 32'h0;
    preload(32'h10, 32'hC000_0008);
    preload(32'h20, 32'h1357_2468);

    // Reset held with both requests high.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
      checkOutput("reset ld_gnt", 32'(bus.ld_gnt), 32'd0);
      checkOutput("reset mem_en", 32'(bus.mem_en), 32'd0);
      checkOutput("reset rvalid", 32'(bus.fetch_rvalid | bus.ld_rvalid), 32'd0);
      checkOutput("reset fetch_rdata", bus.fetch_rdata, 32'd0);
      checkOutput("reset ld_rdata", bus.ld_rdata, 32'd0);
    end
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("release ld_gnt", 32'(bus.ld_gnt), 32'd1);
    nextCycle();
    bus.ld_req    = 1'b0;
    bus.fetch_req = 1'b0;
    repeat (6) nextCycle();

    // Fetch read timing.
    bus.fetch_addr = 32'h10;
    bus.fetch_req  = 1'b1;
    waitGrant(1'b0);
    @(negedge clk);
    checkOutput("fetch mem_en t+1", 32'(bus.mem_en), 32'd1);
    checkOutput("fetch mem_addr", bus.mem_addr, 32'h10);
    @(negedge clk);
    checkOutput("fetch rvalid t+2", 32'(bus.fetch_rvalid), 32'd0);
    @(negedge clk);
    checkOutput("fetch rvalid t+3", 32'(bus.fetch_rvalid), 32'd1);
    checkOutput("fetch rdata", bus.fetch_rdata, 32'hC000_0008);

    // Loader write then readback.
    nextCycle();
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 32'h40;
    bus.ld_wdata = 32'hDEAD_BEEF;
    bus.ld_req   = 1'b1;
    waitGrant(1'b1);
    @(negedge clk);
    checkOutput("ld write mem_we", 32'(bus.mem_we), 32'd1);
    checkOutput("ld write mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    checkOutput("ld write rvalid", 32'(bus.ld_rvalid), 32'd1);
    checkOutput("ld write rdata", bus.ld_rdata, 32'd0);
    nextCycle();
    bus.ld_we  = 1'b0;
    bus.ld_req = 1'b1;
    waitGrant(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("ld read rvalid", 32'(bus.ld_rvalid), 32'd1);
    checkOutput("ld read rdata", bus.ld_rdata, 32'hDEAD_BEEF);

    // Starvation: both requesters held high.
    nextCycle();
    bus.fetch_req = 1'b1;
    bus.ld_req    = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (bus.ld_gnt)    begin seq[n] = 1'b1; n++; end
      if (bus.fetch_gnt) begin seq[n] = 1'b0; n++; end
    end
    checkOutput("starve grant count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("starve seq[%0d]", i), 32'(seq[i]), 32'(expSeq[i]));
    nextCycle();
    bus.fetch_req = 1'b0;
    bus.ld_req    = 1'b0;
    repeat (6) nextCycle();

    // Flush during WAIT drops the response.
    bus.fetch_addr = 32'h30;
    bus.fetch_req  = 1'b1;
    waitGrant(1'b0);
    seen = 1'b0;
    @(negedge clk);
    seen |= bus.fetch_rvalid;
    nextCycle();
    bus.fetch_flush = 1'b1;
    @(negedge clk);
    seen |= bus.fetch_rvalid;
    nextCycle();
    bus.fetch_flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus.fetch_rvalid;
    end
    checkOutput("flush drops rvalid", 32'(seen), 32'd0);
    nextCycle();
    bus.fetch_addr = 32'h20;
    bus.fetch_req  = 1'b1;
    waitGrant(1'b0);
    repeat (3) @(negedge clk);
    checkOutput("post-flush rvalid", 32'(bus.fetch_rvalid), 32'd1);
    checkOutput("post-flush rdata", bus.fetch_rdata, 32'h1357_2468);

    // Flush in IDLE / grant cycle is ignored.
    nextCycle();
    bus.fetch_addr  = 32'h10;
    bus.fetch_req   = 1'b1;
    bus.fetch_flush = 1'b1;
    waitGrant(1'b0);
    bus.fetch_flush = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle flush rvalid", 32'(bus.fetch_rvalid), 32'd1);
    checkOutput("idle flush rdata", bus.fetch_rdata, 32'hC000_0008);

    // Reset during WAIT abandons the access.
    nextCycle();
    bus.fetch_addr = 32'h20;
    bus.fetch_req  = 1'b1;
    waitGrant(1'b0);
    nextCycle();
    rst  = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    seen |= bus.fetch_rvalid;
    nextCycle();
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen |= bus.fetch_rvalid | bus.ld_rvalid;
    end
    checkOutput("mid-reset rvalid", 32'(seen), 32'd0);
    checkOutput("mid-reset fetch_rdata", bus.fetch_rdata, 32'd0);
    nextCycle();
    bus.ld_we   = 1'b0;
    bus.ld_addr = 32'h40;
    bus.ld_req  = 1'b1;
    waitGrant(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("after reset ld rvalid", 32'(bus.ld_rvalid), 32'd1);
    checkOutput("after reset ld rdata", bus.ld_rdata, 32'hDEAD_BEEF);

    // Random traffic against the model.
    repeat (3000) applyStimulus();

    nextCycle();
    rst             = 1'b1;
    bus.fetch_req   = 1'b0;
    bus.ld_req      = 1'b0;
    bus.fetch_flush = 1'b0;
    repeat (10) nextCycle();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
